dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i, input, 1: reset; asynchronous, active-low.
REQ-003 SHALL have cpu_addr_i, input, 32: byte address; tag [31:9], index [8:5], word [4:2].
REQ-004 SHALL have cpu_data_i, input, 32: store data.
REQ-005 SHALL have cpu_MemRead_i / cpu_MemWrite_i, input, 1 each: load / store request.
REQ-006 SHALL have cpu_data_o, output, 32: load data.
REQ-007 SHALL have cpu_stall_o, output, 1: CPU holds request and address while high.
REQ-008 SHALL have sram_addr_o, output, 4: set index to cache SRAM.
REQ-009 SHALL have sram_tag_o, output, 25: {valid, dirty, tag[22:0]} to SRAM.
REQ-010 SHALL have sram_data_o, output, 256: line to SRAM.
REQ-011 SHALL have sram_enable_o / sram_write_o, output, 1 each: SRAM access / write strobe.
REQ-012 SHALL have sram_tag_i, input, 25: hit way tag on hit, LRU victim tag on miss.
REQ-013 SHALL have sram_data_i, input, 256: line matching sram_tag_i.
REQ-014 SHALL have sram_hit_i, input, 1: lookup hit.
REQ-015 SHALL have mem_addr_o, output, 32: line-aligned memory address (bits [4:0] zero).
REQ-016 SHALL have mem_data_o, output, 256: writeback line.
REQ-017 SHALL have mem_enable_o / mem_write_o, output, 1 each: memory request / write.
REQ-018 SHALL have mem_data_i, input, 256 and mem_ack_i, input, 1: refill data, one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-020 SHALL drive sram_addr_o = cpu_addr_i[8:5] and sram_enable_o = req (req = MemRead|MemWrite) in all states.
REQ-021 IDLE, req & sram_hit_i: cpu_stall_o=0 same cycle; cpu_data_o = sram_data_i word [4:2].
REQ-022 IDLE, write hit: sram_write_o=1, sram_tag_o={1,1,tag}, sram_data_o = sram_data_i with addressed word replaced by cpu_data_i; no extra cycles.
REQ-023 MemRead and MemWrite both high SHALL be treated as a write; cpu_data_o still shows the pre-write word.
REQ-024 IDLE, req & ~sram_hit_i: cpu_stall_o=1 combinationally, next state MISS; no request -> stay IDLE, stall 0.
REQ-025 cpu_stall_o SHALL be 1 in every non-IDLE state.
REQ-026 MISS (1 cycle): register victim tag/data; victim valid & dirty -> WRITEBACK, else -> READMISS.
REQ-027 mem_enable_o, mem_write_o, mem_addr_o, mem_data_o SHALL be registered, valid from the first cycle of WRITEBACK/READMISS and held until mem_ack_i.
REQ-028 WRITEBACK: mem_write_o=1, mem_addr_o={victim tag[22:0], index, 5'b0}, mem_data_o=victim line; on mem_ack_i -> READMISS.
REQ-029 READMISS: mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i capture mem_data_i -> READMISSOK, mem_enable_o deasserted next cycle.
REQ-030 READMISSOK (1 cycle): sram_write_o=1, sram_tag_o={1,0,tag}, sram_data_o=captured line; -> IDLE, where access re-evaluates as hit.
REQ-031 mem_ack_i outside WRITEBACK/READMISS SHALL be ignored; memory latency unbounded.
REQ-032 sram_write_o SHALL be 0 except per REQ-022 and REQ-030.

Reset
REQ-033 rst_i low SHALL immediately force IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, captured registers 0, including mid-WRITEBACK/READMISS.
REQ-034 After release, first rising edge SHALL evaluate the request as IDLE.

Verification
REQ-035 Read hit: addr 0x0000_0024, line word1=0xDEADBEEF -> cpu_data_o=0xDEADBEEF, stall 0, no mem_enable_o.
REQ-036 Clean read miss, ack after 10 cycles: addr 0x0000_0400 -> mem_addr_o=0x400 read, SRAM write tag {1,0,0x2}, hit next IDLE cycle.
REQ-037 Dirty miss: victim tag {1,1,0x5}, index 3 -> writeback mem_addr_o=0x0000_0A60 with victim line, then refill read, then SRAM write.
REQ-038 Write hit word 7 with 0x12345678 -> sram_data_o[255:224]=0x12345678, tag dirty 1, stall 0.
REQ-039 Reset pulled low during READMISS -> mem_enable_o=0 without clock, state IDLE, later stray mem_ack_i ignored.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// CPU, cache-SRAM and memory-side signals of the data cache controller.
// The master modport is the controller's view; slave is the environment's.
interface dcache_ctrl_if;
  // CPU side
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  // cache SRAM side
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  // memory side
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate data cache controller. Hits complete in the
// request cycle; a miss optionally writes back the dirty victim line, then
// refills the line from memory and re-runs the access as a hit.
module dcache_ctrl (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

  state_t        state;
  logic [255:0]  victim_data;
  logic [255:0]  refill_data;
  logic [31:0]   mem_addr;
  logic          mem_enable;
  logic          mem_write;

  logic          req;
  logic [22:0]   tag;
  logic [3:0]    idx;
  logic [2:0]    word;
  logic [7:0]    bit_ofs;
  logic [255:0]  merged;

  // byte-offset bits never matter: accesses are whole words
  wire unused_byte_ofs = ^bus.cpu_addr_i[1:0];

  assign req     = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign tag     = bus.cpu_addr_i[31:9];
  assign idx     = bus.cpu_addr_i[8:5];
  assign word    = bus.cpu_addr_i[4:2];
  assign bit_ofs = {word, 5'b0};

  assign bus.sram_addr_o   = idx;
  assign bus.sram_enable_o = req;
  // load data always reflects the line as read, so a combined read+write
  // returns the pre-write word
  assign bus.cpu_data_o    = bus.sram_data_i[bit_ofs +: 32];

  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_data_o    = victim_data;
  assign bus.mem_enable_o  = mem_enable;
  assign bus.mem_write_o   = mem_write;

  // store merge: current line with the addressed word replaced
  always_comb begin
    merged = bus.sram_data_i;
    merged[bit_ofs +: 32] = bus.cpu_data_i;
  end

  // stall and SRAM write strobes; only a write hit in IDLE and the refill
  // cycle ever write the SRAM
  always_comb begin
    bus.cpu_stall_o  = 1'b1;
    bus.sram_write_o = 1'b0;
    bus.sram_tag_o   = {2'b11, tag};
    bus.sram_data_o  = merged;
    case (state)
      IDLE: begin
        bus.cpu_stall_o  = req & ~bus.sram_hit_i;
        bus.sram_write_o = bus.cpu_MemWrite_i & bus.sram_hit_i;
      end
      READMISSOK: begin
        bus.sram_write_o = 1'b1;
        bus.sram_tag_o   = {2'b10, tag};
        bus.sram_data_o  = refill_data;
      end
      default: ;
    endcase
  end

  // miss FSM with registered memory request outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      victim_data <= '0;
      refill_data <= '0;
      mem_addr    <= '0;
      mem_enable  <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !bus.sram_hit_i) state <= MISS;
        end
        MISS: begin
          // SRAM presents the LRU victim during a miss
          victim_data <= bus.sram_data_i;
          mem_enable  <= 1'b1;
          if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
            state     <= WRITEBACK;
            mem_write <= 1'b1;
            mem_addr  <= {bus.sram_tag_i[22:0], idx, 5'b0};
          end else begin
            state     <= READMISS;
            mem_write <= 1'b0;
            mem_addr  <= {tag, idx, 5'b0};
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state     <= READMISS;
            mem_write <= 1'b0;
            mem_addr  <= {tag, idx, 5'b0};
          end
        end
        READMISS: begin
          if (bus.mem_ack_i) begin
            state       <= READMISSOK;
            refill_data <= bus.mem_data_i;
            mem_enable  <= 1'b0;
          end
        end
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a direct-mapped SRAM model and a
// fixed-latency memory model surround the DUT; stimulus pushes expected
// events, a negedge monitor pops and compares them.
module tb_dcache_ctrl;

  localparam int LAT = 10;

  logic clk;
  logic rst;
  dcache_ctrl_if bus ();

  dcache_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {logic wr; logic [31:0] addr; logic [255:0] data;} mem_exp_t;
  typedef struct {logic [24:0] tag; logic [255:0] data;} sram_exp_t;
  logic [31:0] q_load[$];
  mem_exp_t    q_mem[$];
  sram_exp_t   q_sram[$];

  function automatic logic [255:0] mk_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = seed + 32'h0001_0001 * k;
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return mk_line(a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [255:0] put_word(input logic [255:0] l, input int w, input logic [31:0] d);
    logic [255:0] r;
    r = l;
    r[w*32 +: 32] = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // SRAM model: one way per set; tag/data always show the indexed entry
  logic [24:0]  stag [16];
  logic [255:0] sdat [16];
  logic         pl_en = 1'b0;
  logic [3:0]   pl_idx = '0;
  logic [24:0]  pl_tag = '0;
  logic [255:0] pl_dat = '0;
  wire  [3:0]   sidx = bus.cpu_addr_i[8:5];

  assign bus.sram_tag_i  = stag[sidx];
  assign bus.sram_data_i = sdat[sidx];
  assign bus.sram_hit_i  = stag[sidx][24] && (stag[sidx][22:0] == bus.cpu_addr_i[31:9]);

  always @(posedge clk) begin
    if (pl_en) begin
      stag[pl_idx] <= pl_tag;
      sdat[pl_idx] <= pl_dat;
    end else if (bus.sram_enable_o && bus.sram_write_o) begin
      stag[bus.sram_addr_o] <= bus.sram_tag_o;
      sdat[bus.sram_addr_o] <= bus.sram_data_o;
    end
  end

  // memory model: ack LAT cycles after a request appears
  int           cnt = 0;
  logic         mack = 1'b0;
  logic         force_ack = 1'b0;
  logic [255:0] mdat = '0;
  assign bus.mem_ack_i  = mack | force_ack;
  assign bus.mem_data_i = mdat;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_enable_o) begin
        cnt = 0;
        mack = 1'b0;
      end else begin
        cnt  = mack ? 1 : cnt + 1;
        mack = (cnt == LAT);
        if (mack) mdat = line_of(bus.mem_addr_o);
      end
    end
  end

  // monitor: compare every DUT-presented event against the scoreboard
  logic mbusy = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mbusy = 1'b0;
      end else begin
        if (bus.cpu_MemRead_i && !bus.cpu_stall_o) begin
          if (q_load.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL load_unexpected: got %h, want none", bus.cpu_data_o);
          end else chk("load_data", bus.cpu_data_o, q_load.pop_front());
        end
        if (bus.sram_enable_o && bus.sram_write_o) begin
          if (q_sram.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL sram_write_unexpected: got tag %h, want none", bus.sram_tag_o);
          end else begin
            sram_exp_t e;
            e = q_sram.pop_front();
            chk("sram_tag", bus.sram_tag_o, e.tag);
            chk("sram_data", bus.sram_data_o, e.data);
          end
        end
        if (bus.mem_enable_o && !mbusy) begin
          mbusy = 1'b1;
          if (q_mem.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL mem_req_unexpected: got addr %h, want none", bus.mem_addr_o);
          end else begin
            mem_exp_t e;
            e = q_mem.pop_front();
            chk("mem_write", bus.mem_write_o, e.wr);
            chk("mem_addr", bus.mem_addr_o, e.addr);
            if (e.wr) chk("mem_data", bus.mem_data_o, e.data);
          end
        end
        if (bus.mem_ack_i && bus.mem_enable_o) mbusy = 1'b0;
      end
    end
  end

  // one CPU access, held until the stall drops; returns stalled cycles
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, output int stalls);
    bit done;
    @(posedge clk); #1;
    bus.cpu_addr_i = a; bus.cpu_data_i = d;
    bus.cpu_MemRead_i = rd; bus.cpu_MemWrite_i = wr;
    stalls = 0;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) done = 1;
      else stalls++;
    end
    if (!done) begin
      ntests++; nfail++;
      $display("FAIL access_timeout: got stall 1, want 0 at addr %h", a);
    end
    @(posedge clk); #1;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
  endtask

  logic [255:0] l1, l3, l7;
  int st;

  initial begin
    l1 = put_word(mk_line(32'h1000_0000), 1, 32'hDEAD_BEEF);
    l3 = mk_line(32'h3000_0000);
    l7 = mk_line(32'h7000_0000);
    rst = 1'b0;
    bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;

    // preload the SRAM model while the DUT is held in reset
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      pl_idx = 4'(i);
      pl_tag = '0;
      pl_dat = mk_line(32'(i) << 24);
      if (i == 1) begin pl_tag = {2'b10, 23'h0}; pl_dat = l1; end
      if (i == 3) begin pl_tag = {2'b11, 23'h5}; pl_dat = l3; end
      if (i == 7) begin pl_tag = {2'b10, 23'h0}; pl_dat = l7; end
      pl_en = 1'b1;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // reset state
    chk("rst_mem_enable", bus.mem_enable_o, 1'b0);
    chk("rst_mem_write", bus.mem_write_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_stall", bus.cpu_stall_o, 1'b0);
    chk("rst_sram_write", bus.sram_write_o, 1'b0);
    rst = 1'b1;

    // read hit
    q_load.push_back(32'hDEAD_BEEF);
    access(32'h0000_0024, 1, 0, 0, st);
    chk("hit_stalls", st, 0);

    // write hit to word 7
    q_sram.push_back('{tag: {2'b11, 23'h0}, data: put_word(l7, 7, 32'h1234_5678)});
    access(32'h0000_00FC, 0, 1, 32'h1234_5678, st);
    chk("write_hit_stalls", st, 0);
    q_load.push_back(32'h1234_5678);
    access(32'h0000_00FC, 1, 0, 0, st);
    q_load.push_back(l7[6*32 +: 32]);
    access(32'h0000_00F8, 1, 0, 0, st);

    // read and write together: store wins, load shows the old word
    q_load.push_back(32'hDEAD_BEEF);
    q_sram.push_back('{tag: {2'b11, 23'h0}, data: put_word(l1, 1, 32'hCAFE_F00D)});
    access(32'h0000_0024, 1, 1, 32'hCAFE_F00D, st);
    chk("rdwr_stalls", st, 0);

    // clean read miss
    q_mem.push_back('{wr: 1'b0, addr: 32'h0000_0400, data: '0});
    q_sram.push_back('{tag: {2'b10, 23'h2}, data: line_of(32'h0000_0400)});
    q_load.push_back(line_of(32'h0000_0400)[31:0]);
    access(32'h0000_0400, 1, 0, 0, st);
    chk("clean_miss_stalls", st, 3 + LAT);

    // dirty miss: write back victim tag 5 of set 3, then refill
    q_mem.push_back('{wr: 1'b1, addr: 32'h0000_0A60, data: l3});
    q_mem.push_back('{wr: 1'b0, addr: 32'h0000_1260, data: '0});
    q_sram.push_back('{tag: {2'b10, 23'h9}, data: line_of(32'h0000_1260)});
    q_load.push_back(line_of(32'h0000_1260)[63:32]);
    access(32'h0000_1264, 1, 0, 0, st);
    chk("dirty_miss_stalls", st, 3 + 2 * LAT);

    // reset in the middle of a refill
    q_mem.push_back('{wr: 1'b0, addr: 32'h0000_0800, data: '0});
    @(posedge clk); #1;
    bus.cpu_addr_i = 32'h0000_0800; bus.cpu_MemRead_i = 1'b1;
    begin
      bit seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (bus.mem_enable_o) seen = 1;
      end
      chk("readmiss_started", seen, 1'b1);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_enable", bus.mem_enable_o, 1'b0);
    chk("async_rst_mem_addr", bus.mem_addr_o, 32'h0);
    bus.cpu_MemRead_i = 1'b0;
    #1;
    chk("async_rst_stall", bus.cpu_stall_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_mem_enable", bus.mem_enable_o, 1'b0);
    chk("stray_ack_sram_write", bus.sram_write_o, 1'b0);
    chk("stray_ack_stall", bus.cpu_stall_o, 1'b0);

    // cache contents survive the aborted refill
    q_load.push_back(32'hCAFE_F00D);
    access(32'h0000_0024, 1, 0, 0, st);
    chk("post_rst_hit_stalls", st, 0);
    q_load.push_back(line_of(32'h0000_0400)[31:0]);
    access(32'h0000_0400, 1, 0, 0, st);

    repeat (2) @(posedge clk);
    chk("pending_loads", q_load.size(), 0);
    chk("pending_mem", q_mem.size(), 0);
    chk("pending_sram", q_sram.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog");
  end

endmodule
